// File: rtl/fsa_span_pkg.sv
// Shared types and helpers for the fsa span analyser.
package fsa_span_pkg;

  // Widths of the per-channel result fields; the top's default column and
  // segment widths follow these so the struct and the ports line up.
  localparam int SPAN_X_W   = 12;
  localparam int SPAN_SEG_W = 4;

  // Per-channel result as published for one frame.
  typedef struct packed {
    logic                  lft_valid;
    logic [SPAN_X_W-1:0]   lft_edge;
    logic                  rt_valid;
    logic [SPAN_X_W-1:0]   rt_edge;
    logic [SPAN_SEG_W-1:0] seg_cnt;
  } span_res_t;

  // Run counter only needs to count up to the qualifying length.
  function automatic int run_cnt_w(input int min_run);
    return (min_run < 1) ? 1 : $clog2(min_run + 1);
  endfunction

endpackage

// File: rtl/fsa_span_channel.sv
// Per-channel scan-row state: left edge, right edge, run qualification and
// segment counting. Exposes the state as it will be after the current beat
// so the top can latch a result on the same beat that ends the frame.
module fsa_span_channel
  import fsa_span_pkg::*;
#(
  parameter int C_MIN_RUN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                scan,
  input  logic                val,
  input  logic                sol,
  input  logic                eol,
  input  logic [SPAN_X_W-1:0] x,
  output span_res_t           res_nxt
);

  localparam int RUN_W = run_cnt_w(C_MIN_RUN);
  localparam logic [RUN_W-1:0] RUN_MIN = RUN_W'(C_MIN_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [RUN_W-1:0]      run_q, run_b, run_n;
  logic                  lft_open_q, lft_open_b, lft_open_n;
  logic [SPAN_X_W-1:0]   lft_edge_q, lft_edge_b, lft_edge_n;
  logic                  lft_ok_q, lft_ok_b, lft_ok_n;
  logic [SPAN_X_W-1:0]   rt_edge_q, rt_edge_b, rt_edge_n;
  logic                  rt_ok_q, rt_ok_b, rt_ok_n;
  logic [SPAN_SEG_W-1:0] seg_q, seg_b, seg_n;
  logic                  prev_q, prev_b, prev_n;
  logic                  start;

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
    return (v >= RUN_MIN) ? RUN_MIN : v + RUN_ONE;
  endfunction

  function automatic logic [SPAN_SEG_W-1:0] seg_sat_inc(input logic [SPAN_SEG_W-1:0] v);
    return (&v) ? v : v + SPAN_SEG_W'(1);
  endfunction

  // Next-state for one beat: clear at frame start, then apply a scan beat.
  always_comb begin
    run_b      = clr ? '0   : run_q;
    lft_open_b = clr ? 1'b0 : lft_open_q;
    lft_edge_b = clr ? '0   : lft_edge_q;
    lft_ok_b   = clr ? 1'b0 : lft_ok_q;
    rt_edge_b  = clr ? '0   : rt_edge_q;
    rt_ok_b    = clr ? 1'b0 : rt_ok_q;
    seg_b      = clr ? '0   : seg_q;
    prev_b     = clr ? 1'b0 : prev_q;

    run_n      = run_b;
    lft_open_n = lft_open_b;
    lft_edge_n = lft_edge_b;
    lft_ok_n   = lft_ok_b;
    rt_edge_n  = rt_edge_b;
    rt_ok_n    = rt_ok_b;
    seg_n      = seg_b;
    prev_n     = prev_b;
    start      = 1'b0;

    if (scan) begin
      // A run starts on a rising valid or on a valid first column.
      start  = val & (sol | ~prev_b);
      prev_n = val;

      if (!val)       run_n = '0;
      else if (start) run_n = RUN_ONE;
      else            run_n = run_sat_inc(run_b);

      // Right edge tracks the start of the most recent run.
      if (start) begin
        rt_edge_n = x;
        seg_n     = seg_sat_inc(seg_b);
      end

      // Left edge follows the run that begins on the first column.
      if (sol) begin
        lft_open_n = val;
        lft_ok_n   = val & (run_n >= RUN_MIN);
        if (val) lft_edge_n = x;
      end else if (lft_open_b) begin
        if (val) begin
          lft_edge_n = x;
          lft_ok_n   = run_n >= RUN_MIN;
        end else begin
          lft_open_n = 1'b0;
        end
      end

      if (eol) rt_ok_n = val & (run_n >= RUN_MIN);
    end

    res_nxt.lft_valid = lft_ok_n;
    res_nxt.lft_edge  = lft_edge_n;
    res_nxt.rt_valid  = rt_ok_n;
    res_nxt.rt_edge   = rt_edge_n;
    res_nxt.seg_cnt   = seg_n;
  end

  // Channel state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= '0;
      lft_open_q <= 1'b0;
      lft_edge_q <= '0;
      lft_ok_q   <= 1'b0;
      rt_edge_q  <= '0;
      rt_ok_q    <= 1'b0;
      seg_q      <= '0;
      prev_q     <= 1'b0;
    end else begin
      run_q      <= run_n;
      lft_open_q <= lft_open_n;
      lft_edge_q <= lft_edge_n;
      lft_ok_q   <= lft_ok_n;
      rt_edge_q  <= rt_edge_n;
      rt_ok_q    <= rt_ok_n;
      seg_q      <= seg_n;
      prev_q     <= prev_n;
    end
  end

endmodule

// File: rtl/fsa_detect_span.sv
// Per-frame span analyser: registers the column stream, matches the scan
// row, runs C_CH_NUM channel trackers and publishes one result per frame
// over a valid/ready handshake with overrun flagging.
module fsa_detect_span
  import fsa_span_pkg::*;
#(
  parameter int C_IMG_WW  = SPAN_X_W,
  parameter int C_IMG_HW  = 12,
  parameter int C_CH_NUM  = 2,
  parameter int C_MIN_RUN = 4,
  parameter int C_SEG_W   = SPAN_SEG_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_sof,
  input  logic                         s_en,
  input  logic                         s_sol,
  input  logic                         s_eol,
  input  logic                         s_eof,
  input  logic [C_IMG_WW-1:0]          s_x,
  input  logic [C_IMG_HW-1:0]          s_y,
  input  logic [C_CH_NUM-1:0]          s_val,
  input  logic [C_IMG_HW-1:0]          cfg_row,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_row_miss,
  output logic                         res_overrun,
  output logic [C_CH_NUM-1:0]          res_lft_valid,
  output logic [C_CH_NUM*C_IMG_WW-1:0] res_lft_edge,
  output logic [C_CH_NUM-1:0]          res_rt_valid,
  output logic [C_CH_NUM*C_IMG_WW-1:0] res_rt_edge,
  output logic [C_CH_NUM*C_SEG_W-1:0]  res_seg_cnt
);

  logic                  sof_p0, en_p0, sol_p0, eol_p0, eof_p0;
  logic [C_IMG_WW-1:0]   x_p0;
  logic [C_IMG_HW-1:0]   y_p0, cfg_p0;
  logic [C_CH_NUM-1:0]   val_p0;

  logic [C_IMG_HW-1:0]   row_q, row_eff;
  logic                  armed_q, armed_eff;
  logic                  seen_q, seen_n;
  logic                  scan_p0, load_p0;

  span_res_t             ch_nxt [C_CH_NUM];
  span_res_t             res_d  [C_CH_NUM];
  span_res_t             res_p1 [C_CH_NUM];
  logic                  vld_p1, miss_p1, ovr_p1;

  // ---- stage p0: registered beat ----
  // Capture the incoming beat and the row configuration offered with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sof_p0 <= 1'b0;
      en_p0  <= 1'b0;
      sol_p0 <= 1'b0;
      eol_p0 <= 1'b0;
      eof_p0 <= 1'b0;
      x_p0   <= '0;
      y_p0   <= '0;
      val_p0 <= '0;
      cfg_p0 <= '0;
    end else begin
      sof_p0 <= s_sof;
      en_p0  <= s_en;
      sol_p0 <= s_sol;
      eol_p0 <= s_eol;
      eof_p0 <= s_eof;
      x_p0   <= s_x;
      y_p0   <= s_y;
      val_p0 <= s_val;
      cfg_p0 <= cfg_row;
    end
  end

  // Row match: a frame-start beat already uses the row it latches. Matching
  // stays off until the first frame start so a stray frame end after reset
  // reports a missed row.
  always_comb begin
    row_eff   = sof_p0 ? cfg_p0 : row_q;
    armed_eff = sof_p0 | armed_q;
    scan_p0   = en_p0 & armed_eff & (y_p0 == row_eff);
    seen_n    = (sof_p0 ? 1'b0 : seen_q) | scan_p0;
    load_p0   = en_p0 & eof_p0;
  end

  // Frame-level control: latched scan row and whether it has been seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q   <= '0;
      armed_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      if (sof_p0) begin
        row_q   <= cfg_p0;
        armed_q <= 1'b1;
      end
      seen_q <= seen_n;
    end
  end

  for (genvar i = 0; i < C_CH_NUM; i++) begin : g_ch
    fsa_span_channel #(
      .C_MIN_RUN (C_MIN_RUN)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .clr     (sof_p0),
      .scan    (scan_p0),
      .val     (val_p0[i]),
      .sol     (sol_p0),
      .eol     (eol_p0),
      .x       (x_p0),
      .res_nxt (ch_nxt[i])
    );
  end

  // A frame whose scan row never appeared reports no valid edges.
  always_comb begin
    for (int i = 0; i < C_CH_NUM; i++) begin
      res_d[i] = ch_nxt[i];
      if (!seen_n) begin
        res_d[i].lft_valid = 1'b0;
        res_d[i].rt_valid  = 1'b0;
      end
    end
  end

  // ---- stage p1: published result and handshake ----
  // Load on frame end (overwriting an unconsumed result flags overrun),
  // otherwise drop valid once the consumer accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C_CH_NUM; i++) res_p1[i] <= '0;
      vld_p1  <= 1'b0;
      miss_p1 <= 1'b0;
      ovr_p1  <= 1'b0;
    end else if (load_p0) begin
      for (int i = 0; i < C_CH_NUM; i++) res_p1[i] <= res_d[i];
      vld_p1  <= 1'b1;
      miss_p1 <= ~seen_n;
      ovr_p1  <= vld_p1 & ~res_ready;
    end else if (vld_p1 && res_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Flatten the per-channel result onto the output buses.
  always_comb begin
    res_valid     = vld_p1;
    res_row_miss  = miss_p1;
    res_overrun   = ovr_p1;
    res_lft_valid = '0;
    res_lft_edge  = '0;
    res_rt_valid  = '0;
    res_rt_edge   = '0;
    res_seg_cnt   = '0;
    for (int i = 0; i < C_CH_NUM; i++) begin
      res_lft_valid[i]                      = res_p1[i].lft_valid;
      res_lft_edge[i*C_IMG_WW +: C_IMG_WW]  = res_p1[i].lft_edge;
      res_rt_valid[i]                       = res_p1[i].rt_valid;
      res_rt_edge[i*C_IMG_WW +: C_IMG_WW]   = res_p1[i].rt_edge;
      res_seg_cnt[i*C_SEG_W +: C_SEG_W]     = res_p1[i].seg_cnt;
    end
  end

endmodule

// File: tb/tb_fsa_detect_span.sv
// Bench for fsa_detect_span: directed scenarios plus randomized frames,
// checked against a run-list model of the scan row.
module tb_fsa_detect_span;

  localparam int IW = 12;
  localparam int HW = 12;
  localparam int CH = 2;
  localparam int MR = 4;
  localparam int SW = 4;
  localparam int AW = 1 + 2*CH + 2*CH*IW + CH*SW;

  logic               clk, reset;
  logic               s_sof, s_en, s_sol, s_eol, s_eof;
  logic [IW-1:0]      s_x;
  logic [HW-1:0]      s_y, cfg_row;
  logic [CH-1:0]      s_val;
  logic               res_valid, res_ready, res_row_miss, res_overrun;
  logic [CH-1:0]      res_lft_valid, res_rt_valid;
  logic [CH*IW-1:0]   res_lft_edge, res_rt_edge;
  logic [CH*SW-1:0]   res_seg_cnt;

  logic [AW-1:0]      res_all, exp_all, exp_prev;
  logic [CH-1:0]      pat [16][16];
  int                 n_chk, n_fail;

  assign res_all = {res_row_miss, res_lft_valid, res_lft_edge, res_rt_valid, res_rt_edge, res_seg_cnt};

  fsa_detect_span #(
    .C_IMG_WW (IW), .C_IMG_HW (HW), .C_CH_NUM (CH), .C_MIN_RUN (MR), .C_SEG_W (SW)
  ) dut (
    .clk (clk), .reset (reset), .s_sof (s_sof), .s_en (s_en), .s_sol (s_sol),
    .s_eol (s_eol), .s_eof (s_eof), .s_x (s_x), .s_y (s_y), .s_val (s_val),
    .cfg_row (cfg_row), .res_valid (res_valid), .res_ready (res_ready),
    .res_row_miss (res_row_miss), .res_overrun (res_overrun),
    .res_lft_valid (res_lft_valid), .res_lft_edge (res_lft_edge),
    .res_rt_valid (res_rt_valid), .res_rt_edge (res_rt_edge),
    .res_seg_cnt (res_seg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    s_en  = 1'b0; s_sof = 1'b0; s_sol = 1'b0; s_eol = 1'b0; s_eof = 1'b0;
    s_x   = IW'($urandom); s_y = HW'($urandom); s_val = CH'($urandom);
  endtask

  task automatic drive_beat(input logic sof, sol, eol, eof, input int x, y,
                            input logic [CH-1:0] v, input int cfg);
    @(negedge clk);
    s_en = 1'b1; s_sof = sof; s_sol = sol; s_eol = eol; s_eof = eof;
    s_x = x[IW-1:0]; s_y = y[HW-1:0]; s_val = v; cfg_row = cfg[HW-1:0];
  endtask

  // Drives a rows x cols frame from pat; returns 1ns after the edge that
  // captures the last beat (or right after driving beat abort_beat).
  task automatic run_frame(input int rows, cols, cfg, cfg_mid, input bit gaps, input int abort_beat);
    int n;
    n = 0;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < cols; x++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          @(negedge clk);
          drive_idle();
        end
        drive_beat(n == 0, x == 0, x == cols-1, (y == rows-1) && (x == cols-1),
                   x, y, pat[y][x], (n == 0) ? cfg : cfg_mid);
        if (n == abort_beat) return;
        n++;
      end
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic fill_random();
    logic b;
    for (int y = 0; y < 16; y++) begin
      for (int c = 0; c < CH; c++) begin
        b = 1'($urandom_range(0, 1));
        for (int x = 0; x < 16; x++) begin
          if ($urandom_range(0, 3) == 0) b = ~b;
          pat[y][x][c] = b;
        end
      end
    end
  endtask

  // Reference: list the valid runs of the scan row and derive edges from
  // the first and last run.
  task automatic compute_exp(input int rows, cols, cfg);
    logic              miss, b, pb;
    logic [CH-1:0]     lv, rv;
    logic [CH*IW-1:0]  le, re;
    logic [CH*SW-1:0]  sg;
    int                nr, fl, ls, ll;
    miss = (cfg >= rows);
    lv = '0; rv = '0; le = '0; re = '0; sg = '0;
    if (!miss) begin
      for (int c = 0; c < CH; c++) begin
        nr = 0; fl = 0; ls = 0; ll = 0; pb = 1'b0;
        for (int x = 0; x < cols; x++) begin
          b = pat[cfg][x][c];
          if (b && !pb) begin nr++; ls = x; ll = 0; end
          if (b) begin ll++; if (nr == 1) fl++; end
          pb = b;
        end
        lv[c] = pat[cfg][0][c] && (fl >= MR);
        le[c*IW +: IW] = pat[cfg][0][c] ? IW'(fl - 1) : '0;
        rv[c] = pat[cfg][cols-1][c] && (ll >= MR);
        re[c*IW +: IW] = IW'(ls);
        sg[c*SW +: SW] = SW'((nr > 15) ? 15 : nr);
      end
    end
    exp_all = {miss, lv, le, rv, re, sg};
  endtask

  task automatic consume(input int delay);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    n_chk++; if (res_all !== '0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", res_all); end
    n_chk++; if ({res_valid, res_overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {res_valid, res_overrun}); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b expected 0", res_valid); end
  endtask

  task automatic test_edges();
    fill_random();
    for (int x = 0; x < 16; x++) pat[5][x] = {(x <= 2), (x <= 6) || (x >= 10)};
    run_frame(16, 16, 5, 5, 1'b0, -1);
    compute_exp(16, 16, 5);
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL edges_early_valid: got %b expected 0", res_valid); end
    @(posedge clk);
    #1;
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL edges_valid: got %b expected 1", res_valid); end
    n_chk++; if (res_all !== exp_all) begin n_fail++; $display("FAIL edges_result: got %h expected %h", res_all, exp_all); end
    n_chk++; if ({res_lft_valid[0], res_lft_edge[IW-1:0], res_rt_valid[0], res_rt_edge[IW-1:0], res_seg_cnt[SW-1:0]}
                 !== {1'b1, 12'd6, 1'b1, 12'd10, 4'd2}) begin
      n_fail++; $display("FAIL edges_ch0: got %b/%0d %b/%0d seg %0d expected 1/6 1/10 seg 2",
                         res_lft_valid[0], res_lft_edge[IW-1:0], res_rt_valid[0], res_rt_edge[IW-1:0], res_seg_cnt[SW-1:0]);
    end
    n_chk++; if ({res_lft_valid[1], res_rt_valid[1], res_seg_cnt[2*SW-1:SW]} !== {1'b0, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL edges_ch1_short: got %b %b seg %0d expected 0 0 seg 1",
                         res_lft_valid[1], res_rt_valid[1], res_seg_cnt[2*SW-1:SW]);
    end
    consume(0);
  endtask

  task automatic test_row_miss();
    fill_random();
    run_frame(16, 8, 20, 20, 1'b1, -1);
    compute_exp(16, 8, 20);
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL miss_early_valid: got %b expected 0", res_valid); end
    @(posedge clk);
    #1;
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid: got %b expected 1", res_valid); end
    n_chk++; if (res_all !== exp_all) begin n_fail++; $display("FAIL miss_result: got %h expected %h", res_all, exp_all); end
    consume(1);
  endtask

  task automatic test_overrun();
    fill_random();
    run_frame(8, 8, 3, int'($urandom_range(0, 15)), 1'b1, -1);
    compute_exp(8, 8, 3);
    exp_prev = exp_all;
    @(posedge clk);
    #1;
    n_chk++; if ({res_valid, res_overrun} !== 2'b10) begin n_fail++; $display("FAIL ovr_first: got %b expected 10", {res_valid, res_overrun}); end
    fill_random();
    run_frame(8, 8, 2, int'($urandom_range(0, 15)), 1'b1, -1);
    compute_exp(8, 8, 2);
    n_chk++; if (res_all !== exp_prev) begin n_fail++; $display("FAIL ovr_held: got %h expected %h", res_all, exp_prev); end
    @(posedge clk);
    #1;
    n_chk++; if ({res_valid, res_overrun} !== 2'b11) begin n_fail++; $display("FAIL ovr_flag: got %b expected 11", {res_valid, res_overrun}); end
    n_chk++; if (res_all !== exp_all) begin n_fail++; $display("FAIL ovr_replaced: got %h expected %h", res_all, exp_all); end
    consume(0);
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drop: got %b expected 0", res_valid); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame(6, 6, f + 1, int'($urandom_range(0, 15)), 1'b1, -1);
      compute_exp(6, 6, f + 1);
      if (f == 2) res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
    end
    n_chk++; if ({res_valid, res_overrun} !== 2'b10) begin n_fail++; $display("FAIL b2b_flags: got %b expected 10", {res_valid, res_overrun}); end
    n_chk++; if (res_all !== exp_all) begin n_fail++; $display("FAIL b2b_result: got %h expected %h", res_all, exp_all); end
  endtask

  task automatic test_reset_mid();
    fill_random();
    run_frame(16, 16, 5, 5, 1'b0, 5*16 + 7);
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    #1;
    n_chk++; if ({res_valid, res_overrun} !== 2'b00) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 00", {res_valid, res_overrun}); end
    n_chk++; if (res_all !== '0) begin n_fail++; $display("FAIL rstmid_fields: got %h expected 0", res_all); end
    @(negedge clk);
    reset = 1'b0;
    fill_random();
    for (int x = 0; x < 16; x++) pat[5][x][0] = 1'b1;
    run_frame(16, 16, 5, 5, 1'b1, -1);
    compute_exp(16, 16, 5);
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early_valid: got %b expected 0", res_valid); end
    @(posedge clk);
    #1;
    n_chk++; if (res_all !== exp_all) begin n_fail++; $display("FAIL rstmid_result: got %h expected %h", res_all, exp_all); end
    n_chk++; if ({res_lft_valid[0], res_lft_edge[IW-1:0], res_rt_valid[0], res_rt_edge[IW-1:0]} !== {1'b1, 12'd15, 1'b1, 12'd0}) begin
      n_fail++; $display("FAIL rstmid_full_row: got %b/%0d %b/%0d expected 1/15 1/0",
                         res_lft_valid[0], res_lft_edge[IW-1:0], res_rt_valid[0], res_rt_edge[IW-1:0]);
    end
    consume(0);
  endtask

  task automatic test_cfg_change();
    fill_random();
    for (int x = 0; x < 10; x++) begin pat[5][x] = 2'b11; pat[8][x] = 2'b00; end
    pat[8][4] = 2'b01;
    run_frame(12, 10, 5, 8, 1'b1, -1);
    compute_exp(12, 10, 5);
    @(posedge clk);
    #1;
    n_chk++; if (res_all !== exp_all) begin n_fail++; $display("FAIL cfg_same_frame: got %h expected %h", res_all, exp_all); end
    consume(0);
    run_frame(12, 10, 8, int'($urandom_range(0, 15)), 1'b1, -1);
    compute_exp(12, 10, 8);
    @(posedge clk);
    #1;
    n_chk++; if (res_all !== exp_all) begin n_fail++; $display("FAIL cfg_next_frame: got %h expected %h", res_all, exp_all); end
    consume(0);
  endtask

  task automatic test_eof_no_sof();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    for (int x = 0; x < 4; x++) drive_beat(1'b0, x == 0, x == 3, x == 3, x, 0, 2'b11, 0);
    @(posedge clk);
    #1;
    drive_idle();
    @(posedge clk);
    #1;
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL nosof_valid: got %b expected 1", res_valid); end
    n_chk++; if (res_all !== {1'b1, {(AW-1){1'b0}}}) begin n_fail++; $display("FAIL nosof_result: got %h expected miss only", res_all); end
    consume(0);
  endtask

  task automatic test_random();
    int rows, cols, cfg;
    for (int f = 0; f < 25; f++) begin
      rows = $urandom_range(1, 16);
      cols = $urandom_range(1, 16);
      cfg  = $urandom_range(0, rows + 1);
      fill_random();
      run_frame(rows, cols, cfg, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);
      compute_exp(rows, cols, cfg);
      @(posedge clk);
      #1;
      n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid f%0d: got %b expected 1", f, res_valid); end
      n_chk++; if (res_all !== exp_all) begin n_fail++; $display("FAIL rand_result f%0d: got %h expected %h", f, res_all, exp_all); end
      consume(int'($urandom_range(0, 3)));
      n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drop f%0d: got %b expected 0", f, res_valid); end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    res_ready = 1'b0;
    cfg_row = '0;
    drive_idle();
    test_reset();
    test_edges();
    test_row_miss();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_cfg_change();
    test_eof_no_sof();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
